b_bop_arb: RTL and testbench
============================

Name: b_bop_arb

Overview:
- Shares one ternary bitwise `bop` datapath between two requesters, e.g. two issue slots or a core port plus a coprocessor port.
- Each requester presents rd/rs1/rs2 operands and an 8-bit LUT on a valid/ready handshake.
- The block grants one requester per cycle, computes `result[i] = lut[{rd[i],rs2[i],rs1[i]}]` by instantiating b_bop, and registers the result with the winner's ID into a single-entry response buffer with valid/ready backpressure.

Parameters:
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority (requester 0 always wins).

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_rd  in  32  requester 0 third operand (LUT index bit 2).
- req0_rs1  in  32  requester 0 operand (LUT index bit 0).
- req0_rs2  in  32  requester 0 operand (LUT index bit 1).
- req0_lut  in  8  requester 0 truth table.
- req1_valid, req1_ready, req1_rd, req1_rs1, req1_rs2, req1_lut: same as requester 0, for requester 1.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that produced the result.
- rsp_result  out  32  registered bop result.
- busy  out  1  equals rsp_valid; for stall and clock-gate logic.

Behaviour:
- Reset, synchronous, g_reset=1 at a clock edge:
  - rsp_valid=0, rsp_id=0, rsp_result=0, priority pointer=0 (requester 0 preferred).
  - req*_ready is forced 0 while g_reset=1.
  - A held response is discarded; reset mid-operation leaves nothing pending.
- Buffer state, EMPTY (rsp_valid=0) / FULL (rsp_valid=1):
  - can_accept = !rsp_valid | rsp_ready, combinational.
  - Transitions:
    - EMPTY→FULL on grant.
    - FULL→EMPTY on rsp_ready with no grant.
    - FULL→FULL on rsp_ready with a grant (drain and refill in the same cycle, full throughput).
    - FULL with rsp_ready=0: hold; rsp_id and rsp_result stable.
- Arbitration, combinational, only when can_accept=1:
  - Only one valid: grant it.
  - Both valid, RR=1: grant the requester equal to the priority pointer.
  - Both valid, RR=0: grant requester 0.
  - reqN_ready = grantN. At most one ready high per cycle. Ready never asserted when can_accept=0.
  - Ready may depend combinationally on valid and rsp_ready. Valid must not depend on ready (requester rule).
- Pointer update, RR=1:
  - On any grant, pointer <= ~granted_id, so the loser of a tie wins next time.
  - No grant: pointer unchanged.
  - RR=0: pointer stays 0.
- Datapath:
  - Muxes the granted requester's operands and LUT into one b_bop instance.
  - On grant: rsp_result <= bop output; rsp_id <= granted_id; rsp_valid <= 1.
- Latency and throughput:
  - Accept in cycle N; rsp_valid=1 in cycle N+1.
  - Throughput one op/cycle when rsp_ready is held high.
- Operand capture: operands are sampled only in the grant cycle. The requester may change them after its handshake.
- No reordering: responses leave in grant order; only one is in flight.

Test Plan:
- Reset then idle: g_reset=1 for 2 cycles with both valid=1 → req0_ready=req1_ready=0, rsp_valid=0. Release → req0 granted first (pointer=0).
- Single op, XOR: req0 rs1=0xF0F0F0F0, rs2=0xFF00FF00, rd=0, lut=0x66, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=0x0FF00FF0.
- Three-input majority: req1 rs1=0xAAAAAAAA, rs2=0xCCCCCCCC, rd=0xF0F0F0F0, lut=0xE8 → rsp_result=0xE8E8E8E8, rsp_id=1.
- Round-robin contention, RR=1: both valid for 4 cycles, rsp_ready=1 → grant sequence 0,1,0,1; rsp_id follows one cycle later; no bubbles.
- Backpressure: rsp_valid=1 with rsp_ready=0 for 3 cycles, both valid:
  - Both readies stay 0; rsp_result stable.
  - Raise rsp_ready → drain and new grant in the same cycle; rsp_valid stays 1.
- Fixed priority and mid-op reset:
  - RR=0, both valid for 3 cycles → always id 0.
  - Assert g_reset while FULL → next cycle rsp_valid=0, rsp_result=0, pointer=0.

Source files
------------

// File: rtl/b_bop_arb.sv
// b_bop_arb: two requesters share one ternary bitwise LUT datapath (b_bop).
// Each cycle at most one requester is granted. Its operands pass through b_bop
// and the result is registered, tagged with the winner's ID, into a
// single-entry response buffer that uses valid/ready backpressure.

// One lane: every bit looks up its 3-bit index {rd,rs2,rs1} in the 8-entry table.
module b_bop_lane #(
  parameter int VEC_W = 8
) (
  input  logic [VEC_W-1:0] i_rd,
  input  logic [VEC_W-1:0] i_rs1,
  input  logic [VEC_W-1:0] i_rs2,
  input  logic [7:0]       i_lut,
  output logic [VEC_W-1:0] o_res
);
  // Per-bit truth-table lookup.
  always_comb begin
    o_res = '0;
    for (int b = 0; b < VEC_W; b++) begin
      o_res[b] = i_lut[{i_rd[b], i_rs2[b], i_rs1[b]}];
    end
  end
endmodule

// Full-width ternary bitwise op. The 32-bit word is split into NUM_LANES lanes
// of VEC_W bits each, and every lane uses the same LUT.
module b_bop #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] i_rd,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] i_rs1,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] i_rs2,
  input  logic [7:0]                      i_lut,
  output logic [NUM_LANES-1:0][VEC_W-1:0] o_res
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    b_bop_lane #(.VEC_W(VEC_W)) u_lane (
      .i_rd  (i_rd[l]),
      .i_rs1 (i_rs1[l]),
      .i_rs2 (i_rs2[l]),
      .i_lut (i_lut),
      .o_res (o_res[l])
    );
  end
endmodule

module b_bop_arb #(
  parameter bit RR = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_rd,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [7:0]  req0_lut,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_rd,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [7:0]  req1_lut,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        busy
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [7:0]  lut;
  } bop_req_t;

  logic        r_valid;
  logic        r_id;
  logic [31:0] r_result;
  logic        r_ptr;

  logic        w_can_accept;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any;
  logic        w_gnt_id;
  bop_req_t    w_req0;
  bop_req_t    w_req1;
  bop_req_t    w_sel;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_res;

  assign w_req0 = '{rd: req0_rd, rs1: req0_rs1, rs2: req0_rs2, lut: req0_lut};
  assign w_req1 = '{rd: req1_rd, rs1: req1_rs1, rs2: req1_rs2, lut: req1_lut};

  // The buffer can take a new result when it is empty or is draining this cycle.
  assign w_can_accept = !r_valid | rsp_ready;

  // Grant logic. A lone valid always wins. A tie goes to r_ptr in RR mode and
  // to requester 0 otherwise. No grant is issued during reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!g_reset && w_can_accept) begin
      if (req0_valid && req1_valid) begin
        if (RR && r_ptr) w_gnt1 = 1'b1;
        else             w_gnt0 = 1'b1;
      end else if (req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_any      = w_gnt0 | w_gnt1;
  assign w_gnt_id   = w_gnt1;
  assign w_sel      = w_gnt_id ? w_req1 : w_req0;
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  b_bop #(.NUM_LANES(NUM_LANES), .VEC_W(VEC_W)) u_bop (
    .i_rd  (w_sel.rd),
    .i_rs1 (w_sel.rs1),
    .i_rs2 (w_sel.rs2),
    .i_lut (w_sel.lut),
    .o_res (w_res)
  );

  // Response buffer and priority pointer. A grant refills the buffer, and it
  // may drain in the same cycle. The buffer holds while stalled. On each grant
  // the pointer moves to the other requester.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_valid  <= 1'b0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_ptr    <= 1'b0;
    end else begin
      if (w_any) begin
        r_valid  <= 1'b1;
        r_id     <= w_gnt_id;
        r_result <= w_res;
      end else if (rsp_ready) begin
        r_valid  <= 1'b0;
      end
      if (RR && w_any) r_ptr <= ~w_gnt_id;
    end
  end

  assign rsp_valid  = r_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign busy       = r_valid;
endmodule

// File: tb/tb_b_bop_arb.sv
// Scoreboard bench for b_bop_arb. Two instances run side by side on shared
// stimulus: u_rr uses round-robin and u_fp uses fixed priority. Every grant the
// stimulus expects pushes a hand-computed result into that instance's queue,
// and a monitor checks the held response against the queue head.
module tb_b_bop_arb;
  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy;
  logic [31:0] rd0, rs10, rs20, rd1, rs11, rs21;
  logic [7:0]  lut0, lut1;
  logic [31:0] e0, e1;

  logic        a_r0, a_r1, a_v, a_id, a_busy;
  logic [31:0] a_res;
  logic        b_r0, b_r1, b_v, b_id, b_busy;
  logic [31:0] b_res;

  exp_t qa[$];
  exp_t qb[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  b_bop_arb #(.RR(1'b1)) u_rr (
    .g_clk(clk), .g_reset(rst),
    .req0_valid(v0), .req0_ready(a_r0), .req0_rd(rd0), .req0_rs1(rs10), .req0_rs2(rs20), .req0_lut(lut0),
    .req1_valid(v1), .req1_ready(a_r1), .req1_rd(rd1), .req1_rs1(rs11), .req1_rs2(rs21), .req1_lut(lut1),
    .rsp_valid(a_v), .rsp_ready(rdy), .rsp_id(a_id), .rsp_result(a_res), .busy(a_busy)
  );

  b_bop_arb #(.RR(1'b0)) u_fp (
    .g_clk(clk), .g_reset(rst),
    .req0_valid(v0), .req0_ready(b_r0), .req0_rd(rd0), .req0_rs1(rs10), .req0_rs2(rs20), .req0_lut(lut0),
    .req1_valid(v1), .req1_ready(b_r1), .req1_rd(rd1), .req1_rs1(rs11), .req1_rs2(rs21), .req1_lut(lut1),
    .rsp_valid(b_v), .rsp_ready(rdy), .rsp_id(b_id), .rsp_result(b_res), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. ga/gb give the expected grant for u_rr/u_fp
  // (-1 means no grant).
  task automatic cyc(input logic iv0, input logic iv1, input logic irdy, input int ga, input int gb);
    exp_t t;
    v0 = iv0; v1 = iv1; rdy = irdy;
    @(negedge clk);
    chk("rr_ready0", {31'd0, a_r0}, {31'd0, ga == 0});
    chk("rr_ready1", {31'd0, a_r1}, {31'd0, ga == 1});
    chk("fp_ready0", {31'd0, b_r0}, {31'd0, gb == 0});
    chk("fp_ready1", {31'd0, b_r1}, {31'd0, gb == 1});
    if (ga >= 0) begin
      t.id = (ga == 1); t.res = (ga == 1) ? e1 : e0; qa.push_back(t);
    end
    if (gb >= 0) begin
      t.id = (gb == 1); t.res = (gb == 1) ? e1 : e0; qb.push_back(t);
    end
    @(posedge clk); #1;
  endtask

  // Check each held response against the oldest expected entry. Pop the entry
  // when the consumer takes the response.
  always @(negedge clk) begin
    chk("rr_busy", {31'd0, a_busy}, {31'd0, a_v});
    chk("fp_busy", {31'd0, b_busy}, {31'd0, b_v});
    if (a_v === 1'b1) begin
      if (qa.size() == 0) chk("rr_unexpected_rsp", {31'd0, a_v}, 32'd0);
      else begin
        chk("rr_rsp_id", {31'd0, a_id}, {31'd0, qa[0].id});
        chk("rr_rsp_result", a_res, qa[0].res);
        if (rdy) void'(qa.pop_front());
      end
    end
    if (b_v === 1'b1) begin
      if (qb.size() == 0) chk("fp_unexpected_rsp", {31'd0, b_v}, 32'd0);
      else begin
        chk("fp_rsp_id", {31'd0, b_id}, {31'd0, qb[0].id});
        chk("fp_rsp_result", b_res, qb[0].res);
        if (rdy) void'(qb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
    // req0: XOR of rs1/rs2 (rd=0). req1: three-input majority.
    rd0 = 32'h0; rs10 = 32'hF0F0F0F0; rs20 = 32'hFF00FF00; lut0 = 8'h66; e0 = 32'h0FF00FF0;
    rd1 = 32'hF0F0F0F0; rs11 = 32'hAAAAAAAA; rs21 = 32'hCCCCCCCC; lut1 = 8'hE8; e1 = 32'hE8E8E8E8;

    // Reset with both requesters valid: no ready, empty buffer.
    cyc(1, 1, 1, -1, -1);
    cyc(1, 1, 1, -1, -1);
    chk("rst_rr_valid", {31'd0, a_v}, 32'd0);
    chk("rst_rr_result", a_res, 32'd0);
    chk("rst_fp_valid", {31'd0, b_v}, 32'd0);
    rst = 1'b0;

    // Release: pointer starts at 0, so req0 wins. Then single XOR, then majority.
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 1);

    // Contention: req0 = AND3 with rd=FFFF0000 -> F0000000.
    rd0 = 32'hFFFF0000; lut0 = 8'h80; e0 = 32'hF0000000;
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0);

    // Backpressure: the held result must stay stable while req0 switches to
    // NOR3 -> 0000000F.
    lut0 = 8'h01; e0 = 32'h0000000F;
    cyc(1, 1, 0, -1, -1);
    cyc(1, 1, 0, -1, -1);
    cyc(1, 1, 0, -1, -1);
    cyc(1, 1, 1, 0, 0);
    chk("refill_rr_valid", {31'd0, a_v}, 32'd1);
    chk("refill_fp_valid", {31'd0, b_v}, 32'd1);
    // Pointer is now 1, so u_rr gives a tie to req1.
    rd0 = 32'h0; lut0 = 8'h66; e0 = 32'h0FF00FF0;
    cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 1, -1, -1);
    chk("drain_rr_valid", {31'd0, a_v}, 32'd0);
    chk("drain_fp_valid", {31'd0, b_v}, 32'd0);

    // Mid-op reset: fill the buffer, then reset while it is FULL.
    cyc(1, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 1, 0, -1, -1);
    qa.delete(); qb.delete();
    chk("midrst_rr_valid", {31'd0, a_v}, 32'd0);
    chk("midrst_rr_result", a_res, 32'd0);
    chk("midrst_rr_id", {31'd0, a_id}, 32'd0);
    chk("midrst_fp_valid", {31'd0, b_v}, 32'd0);
    chk("midrst_fp_result", b_res, 32'd0);
    rst = 1'b0;
    // The pointer was 1 before reset and must now be 0, so req0 wins.
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 1, -1, -1);
    chk("rr_queue_empty", qa.size(), 32'd0);
    chk("fp_queue_empty", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
